vend_sequencer: RTL and testbench

- Control FSM sequencing the beverage dispenser datapath: accepts coins, accumulates credit, arbitrates between three selection buttons and checks price.
- Drives one-hot dispense outputs for a fixed duration, then returns change.
- Sits between the coin/button front end and the dispense actuators; all credit arithmetic is in cents.

---
 rtl/vend_sequencer_if.sv | 31 +++
 rtl/vend_sequencer.sv | 164 ++++++++++++++++
 tb/tb_vend_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/vend_sequencer_if.sv
// Front-end / actuator bundle for the vending sequencer.
// master drives coins and buttons; slave is the sequencer itself.
interface vend_sequencer_if;
  logic       coin_valid;
  logic [1:0] coin_code;
  logic       inbev1;
  logic       inbev2;
  logic       inbev3;
  logic       cancel;
  logic [9:0] credit;
  logic       outbev1;
  logic       outbev2;
  logic       outbev3;
  logic       change_valid;
  logic [9:0] change_amt;
  logic       coin_reject;
  logic       insufficient;
  logic       busy;

  modport master (
    output coin_valid, coin_code, inbev1, inbev2, inbev3, cancel,
    input  credit, outbev1, outbev2, outbev3, change_valid, change_amt,
           coin_reject, insufficient, busy
  );

  modport slave (
    input  coin_valid, coin_code, inbev1, inbev2, inbev3, cancel,
    output credit, outbev1, outbev2, outbev3, change_valid, change_amt,
           coin_reject, insufficient, busy
  );
endinterface

// File: rtl/vend_sequencer.sv
// Beverage dispenser control FSM: coin credit, button arbitration, timed
// one-hot dispense and change return. All amounts are in cents.
module vend_sequencer #(
  parameter int PRICE1      = 75,
  parameter int PRICE2      = 100,
  parameter int PRICE3      = 125,
  parameter int DISP_CYCLES = 4,
  parameter int TIMEOUT     = 1000
)(
  input logic             clk,
  input logic             rst,
  vend_sequencer_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int DW = $clog2(DISP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;

  state_t          state_q;
  logic [9:0]      credit_q;
  logic [9:0]      chg_q;
  logic [9:0]      change_amt_q;
  logic            change_valid_q;
  logic            coin_reject_q;
  logic            insufficient_q;
  logic            busy_q;
  logic [2:0]      bev_q;
  logic [TW-1:0]   tmr_q;
  logic [DW-1:0]   disp_q;

  logic [9:0]  coin_val;
  logic [10:0] coin_sum;
  logic        coin_ok;
  logic [2:0]  sel_oh;
  logic [9:0]  sel_price;
  logic        sel_any;
  logic        sel_ok;
  logic        tmo;

  always_comb begin
    coin_val = 10'd0;
    case (bus.coin_code)
      2'b00: coin_val = 10'd5;
      2'b01: coin_val = 10'd10;
      2'b10: coin_val = 10'd25;
      2'b11: coin_val = 10'd100;
      default: coin_val = 10'd0;
    endcase
  end

  // 11-bit sum so a carry out means the credit register would overflow
  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_ok  = ~coin_sum[10];

  always_comb begin
    sel_oh    = 3'b000;
    sel_price = 10'd0;
    if (bus.inbev1) begin
      sel_oh    = 3'b001;
      sel_price = 10'(PRICE1);
    end else if (bus.inbev2) begin
      sel_oh    = 3'b010;
      sel_price = 10'(PRICE2);
    end else if (bus.inbev3) begin
      sel_oh    = 3'b100;
      sel_price = 10'(PRICE3);
    end
  end

  assign sel_any = |sel_oh;
  assign sel_ok  = credit_q >= sel_price;
  // Counter lags by one: the edge that sees TIMEOUT-1 is the TIMEOUT-th idle edge
  assign tmo     = tmr_q == TW'(TIMEOUT - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      credit_q       <= 10'd0;
      chg_q          <= 10'd0;
      change_amt_q   <= 10'd0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
      busy_q         <= 1'b0;
      bev_q          <= 3'b000;
      tmr_q          <= '0;
      disp_q         <= '0;
    end else begin
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
      change_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          credit_q <= 10'd0;
          busy_q   <= 1'b0;
          if (bus.coin_valid) begin
            credit_q <= coin_val;
            tmr_q    <= '0;
            state_q  <= CREDIT;
          end
        end
        CREDIT: begin
          if (bus.cancel || tmo) begin
            state_q        <= CHANGE;
            busy_q         <= 1'b1;
            chg_q          <= credit_q;
            credit_q       <= 10'd0;
            change_valid_q <= credit_q != 10'd0;
            if (credit_q != 10'd0) change_amt_q <= credit_q;
            coin_reject_q  <= bus.coin_valid;
          end else if (sel_any && sel_ok) begin
            state_q       <= DISPENSE;
            busy_q        <= 1'b1;
            bev_q         <= sel_oh;
            chg_q         <= credit_q - sel_price;
            disp_q        <= '0;
            coin_reject_q <= bus.coin_valid;
          end else begin
            insufficient_q <= sel_any;
            tmr_q          <= tmr_q + TW'(1);
            if (bus.coin_valid) begin
              if (coin_ok) begin
                credit_q <= coin_sum[9:0];
                tmr_q    <= '0;
              end else begin
                coin_reject_q <= 1'b1;
              end
            end
          end
        end
        DISPENSE: begin
          coin_reject_q <= bus.coin_valid;
          if (disp_q == DW'(DISP_CYCLES - 1)) begin
            state_q        <= CHANGE;
            bev_q          <= 3'b000;
            credit_q       <= 10'd0;
            change_valid_q <= chg_q != 10'd0;
            if (chg_q != 10'd0) change_amt_q <= chg_q;
          end else begin
            disp_q <= disp_q + DW'(1);
          end
        end
        CHANGE: begin
          coin_reject_q <= bus.coin_valid;
          busy_q        <= 1'b0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.credit       = credit_q;
  assign bus.outbev1      = bev_q[0];
  assign bus.outbev2      = bev_q[1];
  assign bus.outbev3      = bev_q[2];
  assign bus.change_valid = change_valid_q;
  assign bus.change_amt   = change_amt_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.insufficient = insufficient_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer; change strobes are checked against a
// queue of expected refunds pushed as each purchase/cancel is driven.
module tb_vend_sequencer;
  localparam int DISP = 4;
  localparam int TMO  = 1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vend_sequencer_if bus();

  vend_sequencer #(
    .PRICE1(75), .PRICE2(100), .PRICE3(125),
    .DISP_CYCLES(DISP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] code);
    bus.coin_valid = 1'b1;
    bus.coin_code  = code;
    tick();
    bus.coin_valid = 1'b0;
  endtask

  // Scoreboard: every change strobe must match the oldest expected refund
  always @(negedge clk) begin
    int e;
    if (rst && bus.change_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed change %0d expected none", bus.change_amt);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (bus.change_amt === 10'(e)) else begin
          errors++;
          $error("FAIL sb_change: observed %0d expected %0d", bus.change_amt, e);
        end
      end
    end
  end

  initial begin
    int n;
    bus.coin_valid = 1'b0;
    bus.coin_code  = 2'b00;
    bus.inbev1     = 1'b0;
    bus.inbev2     = 1'b0;
    bus.inbev3     = 1'b0;
    bus.cancel     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_credit", bus.credit, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_outbev", {bus.outbev3, bus.outbev2, bus.outbev1}, 0);
    chk("rst_change_amt", bus.change_amt, 0);
    chk("rst_change_valid", bus.change_valid, 0);
    rst = 1'b1;
    tick();

    // 75c exact purchase of beverage 1: no change
    coin(2'b10); coin(2'b10); coin(2'b10);
    chk("t1_credit", bus.credit, 75);
    bus.inbev1 = 1'b1; tick(); bus.inbev1 = 1'b0;
    chk("t1_credit_hold", bus.credit, 75);
    for (int i = 0; i < DISP; i++) begin
      chk("t1_outbev1", bus.outbev1, 1);
      chk("t1_others", {bus.outbev3, bus.outbev2}, 0);
      chk("t1_busy", bus.busy, 1);
      tick();
    end
    chk("t1_chg_outbev", bus.outbev1, 0);
    chk("t1_chg_busy", bus.busy, 1);
    chk("t1_chg_valid", bus.change_valid, 0);
    chk("t1_chg_credit", bus.credit, 0);
    tick();
    chk("t1_idle_busy", bus.busy, 0);

    // 125c for beverage 2 at 100c: 25c change
    coin(2'b11); coin(2'b10);
    chk("t2_credit", bus.credit, 125);
    exp_q.push_back(125 - 100);
    bus.inbev2 = 1'b1; tick(); bus.inbev2 = 1'b0;
    for (int i = 0; i < DISP; i++) begin
      chk("t2_outbev2", {bus.outbev3, bus.outbev2, bus.outbev1}, 3'b010);
      tick();
    end
    chk("t2_chg_valid", bus.change_valid, 1);
    chk("t2_chg_amt", bus.change_amt, 25);
    tick();
    chk("t2_idle", bus.busy, 0);
    chk("t2_strobe_once", bus.change_valid, 0);

    // Insufficient credit, then priority between simultaneous buttons
    coin(2'b10); coin(2'b10);
    bus.inbev3 = 1'b1; tick(); bus.inbev3 = 1'b0;
    chk("t3_insuf", bus.insufficient, 1);
    chk("t3_credit", bus.credit, 50);
    chk("t3_busy", bus.busy, 0);
    tick();
    chk("t3_insuf_once", bus.insufficient, 0);
    coin(2'b10);
    bus.inbev1 = 1'b1; bus.inbev3 = 1'b1; tick();
    bus.inbev1 = 1'b0; bus.inbev3 = 1'b0;
    chk("t3_prio", {bus.outbev3, bus.outbev2, bus.outbev1}, 3'b001);
    repeat (DISP) tick();
    chk("t3_chg_valid", bus.change_valid, 0);
    tick();

    // Credit overflow rejection, then coin during dispense
    repeat (10) coin(2'b11);
    chk("t4_credit1000", bus.credit, 1000);
    coin(2'b10);
    chk("t4_reject", bus.coin_reject, 1);
    chk("t4_credit_kept", bus.credit, 1000);
    tick();
    chk("t4_reject_once", bus.coin_reject, 0);
    coin(2'b00);
    chk("t4_credit1005", bus.credit, 1005);
    exp_q.push_back(1005 - 125);
    bus.inbev3 = 1'b1; tick(); bus.inbev3 = 1'b0;
    chk("t4_outbev3", bus.outbev3, 1);
    coin(2'b01);
    chk("t4_disp_reject", bus.coin_reject, 1);
    chk("t4_disp_credit", bus.credit, 1005);
    repeat (DISP - 1) tick();
    chk("t4_chg_amt", bus.change_amt, 880);
    tick();

    // Cancel beats a simultaneous selection
    coin(2'b10); coin(2'b01);
    exp_q.push_back(35);
    bus.cancel = 1'b1; bus.inbev1 = 1'b1; tick();
    bus.cancel = 1'b0; bus.inbev1 = 1'b0;
    chk("t5_no_disp", {bus.outbev3, bus.outbev2, bus.outbev1}, 0);
    chk("t5_cancel_valid", bus.change_valid, 1);
    chk("t5_cancel_amt", bus.change_amt, 35);
    chk("t5_cancel_credit", bus.credit, 0);
    tick();

    // Idle timeout refund, TMO cycles after the accepted coin
    coin(2'b01);
    exp_q.push_back(10);
    n = 0;
    while (bus.change_valid !== 1'b1 && n < TMO + 20) begin
      tick();
      n++;
    end
    chk("t5_timeout_cycles", n, TMO);
    chk("t5_timeout_amt", bus.change_amt, 10);
    tick();
    chk("t5_timeout_idle", bus.busy, 0);

    // Asynchronous reset in the middle of dispensing
    coin(2'b11);
    bus.inbev2 = 1'b1; tick(); bus.inbev2 = 1'b0;
    tick();
    chk("t6_pre_outbev2", bus.outbev2, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_outbev2", bus.outbev2, 0);
    chk("t6_rst_credit", bus.credit, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_change_amt", bus.change_amt, 0);
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < DISP + 3; i++) begin
      tick();
      chk("t6_no_change", bus.change_valid, 0);
    end
    chk("t6_idle_busy", bus.busy, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
